// File: rtl/rsa_job_scheduler.sv
// ============================================================================
// Module   : rsa_job_scheduler
// Purpose  : Shares one key-inverter and one mod-exp engine between two
//            requesters: key generation, then round-robin encrypt/decrypt jobs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rsa_job_scheduler #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     p,
    input  logic [WIDTH-1:0]     q,
    input  logic                 key_load,
    output logic                 key_valid,
    output logic                 key_err,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 mode0,
    input  logic                 mode1,
    input  logic [WIDTH-1:0]     msg0,
    input  logic [WIDTH-1:0]     msg1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic                 inv_rst,
    input  logic                 inv_finish,
    input  logic [2*WIDTH-1:0]   key_e,
    input  logic [2*WIDTH-1:0]   key_d,
    output logic                 exp_rst,
    input  logic                 exp_finish,
    output logic [2*WIDTH-1:0]   exp_msg,
    output logic [2*WIDTH-1:0]   exp_exponent,
    output logic [2*WIDTH-1:0]   exp_modulo,
    input  logic [2*WIDTH-1:0]   exp_result
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY_RST  = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_EXP_RST  = 3'd3,
        S_EXP_WAIT = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    state_t               r_state;
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic [2*WIDTH-1:0]   r_e;
    logic [2*WIDTH-1:0]   r_d;
    logic [15:0]          r_cnt;
    logic                 r_last;
    logic                 r_owner;

    logic                 w_win;
    logic                 w_mode;
    logic [WIDTH-1:0]     w_msg;
    logic [2*WIDTH-1:0]   w_product;

    // On a tie the requester that was not served last wins.
    assign w_win     = (req0 & req1) ? ~r_last : req1;
    assign w_mode    = w_win ? mode1 : mode0;
    assign w_msg     = w_win ? msg1  : msg0;
    assign w_product = {{WIDTH{1'b0}}, r_p} * {{WIDTH{1'b0}}, r_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_p          <= '0;
            r_q          <= '0;
            r_e          <= '0;
            r_d          <= '0;
            r_cnt        <= '0;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            key_valid    <= 1'b0;
            key_err      <= 1'b0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            result       <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            inv_rst      <= 1'b1;
            exp_rst      <= 1'b1;
            exp_msg      <= '0;
            exp_exponent <= '0;
            exp_modulo   <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_load) begin
                        r_p       <= p;
                        r_q       <= q;
                        key_valid <= 1'b0;
                        key_err   <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_KEY_RST;
                    end else if (key_valid && (req0 || req1)) begin
                        gnt0         <= ~w_win;
                        gnt1         <= w_win;
                        exp_msg      <= {{WIDTH{1'b0}}, w_msg};
                        exp_exponent <= w_mode ? r_e : r_d;
                        r_owner      <= w_win;
                        busy         <= 1'b1;
                        r_state      <= S_EXP_RST;
                    end
                end
                S_KEY_RST: begin
                    r_cnt   <= '0;
                    inv_rst <= 1'b0;
                    r_state <= S_KEY_WAIT;
                end
                S_KEY_WAIT: begin
                    if (inv_finish) begin
                        r_e        <= key_e;
                        r_d        <= key_d;
                        exp_modulo <= w_product;
                        key_valid  <= 1'b1;
                        inv_rst    <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == c_timeout) begin
                        key_err <= 1'b1;
                        inv_rst <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_EXP_RST: begin
                    // exp_finish is deliberately not looked at while the engine is in reset.
                    r_cnt   <= '0;
                    exp_rst <= 1'b0;
                    r_state <= S_EXP_WAIT;
                end
                S_EXP_WAIT: begin
                    if (exp_finish || (r_cnt == c_timeout)) begin
                        result  <= exp_finish ? exp_result : '0;
                        err     <= ~exp_finish;
                        done0   <= ~r_owner;
                        done1   <= r_owner;
                        exp_rst <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    r_last  <= r_owner;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    inv_rst <= 1'b1;
                    exp_rst <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rsa_job_scheduler.sv
// ============================================================================
// Module   : tb_rsa_job_scheduler
// Purpose  : Directed and random job sequences against engine models and a
//            modular-exponentiation reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rsa_job_scheduler;

    localparam int W  = 32;
    localparam int TO = 20;
    localparam logic [63:0] c_e = 64'd17;
    localparam logic [63:0] c_d = 64'd2753;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  p = '0, q = '0;
    logic          key_load = 1'b0;
    logic          key_valid, key_err;
    logic          req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
    logic [W-1:0]  msg0 = '0, msg1 = '0;
    logic          gnt0, gnt1, done0, done1, err, busy;
    logic [63:0]   result;
    logic          inv_rst, exp_rst;
    logic          inv_finish = 1'b0, exp_finish = 1'b0;
    logic [63:0]   key_e, key_d, exp_msg, exp_exponent, exp_modulo;
    logic [63:0]   exp_result = '0;

    int  checks = 0;
    int  errors = 0;
    bit  inv_hang = 1'b0;
    bit  exp_hang = 1'b0;
    int  exp_lat = 5;
    int  icnt = 0;
    int  ecnt = 0;
    logic [63:0] n_mod;

    assign key_e = c_e;
    assign key_d = c_d;

    rsa_job_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .p(p), .q(q), .key_load(key_load),
        .key_valid(key_valid), .key_err(key_err),
        .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
        .msg0(msg0), .msg1(msg1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
        .inv_rst(inv_rst), .inv_finish(inv_finish), .key_e(key_e), .key_d(key_d),
        .exp_rst(exp_rst), .exp_finish(exp_finish), .exp_msg(exp_msg),
        .exp_exponent(exp_exponent), .exp_modulo(exp_modulo), .exp_result(exp_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r, x, mm;
        if (m == 64'd0) return 64'd0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        x  = {64'd0, b} % mm;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[63:0];
    endfunction

    // Inverter model: finishes 10 cycles after leaving reset unless hung.
    always @(posedge clk) begin
        if (inv_rst) begin
            icnt       <= 0;
            inv_finish <= 1'b0;
        end else begin
            icnt       <= icnt + 1;
            inv_finish <= !inv_hang && (icnt == 9);
        end
    end

    always @(posedge clk) begin
        if (exp_rst) begin
            ecnt       <= 0;
            exp_finish <= 1'b0;
        end else begin
            ecnt       <= ecnt + 1;
            exp_finish <= !exp_hang && (ecnt == exp_lat);
            if (!exp_hang && (ecnt == exp_lat))
                exp_result <= modexp(exp_msg, exp_exponent, exp_modulo);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One complete job: grant of the expected requester, operands, then completion.
    task automatic do_job(input int who, input logic [63:0] res, input logic e_err,
                          input logic [63:0] expo, input logic [63:0] m);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (gnt0 || gnt1) seen = 1'b1;
        end
        chk("gnt_seen", seen, 1);
        if (seen) begin
            chk("gnt_owner", {gnt1, gnt0}, (who == 1) ? 2'b10 : 2'b01);
            chk("exp_exponent", exp_exponent, expo);
            chk("exp_msg", exp_msg, m);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done0 || done1) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("done_owner", {done1, done0}, (who == 1) ? 2'b10 : 2'b01);
            chk("result", result, res);
            chk("err", err, e_err);
        end
    endtask

    task automatic wait_high(input string tag, input int which, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if ((which == 0 && key_valid) || (which == 1 && key_err)) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        bit          seen;
        bit          pend0, pend1;
        int          mlast, win, cnt;
        logic [63:0] ex;

        n_mod = 64'd61 * 64'd53;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_inv_rst", inv_rst, 1);
        chk("rst_exp_rst", exp_rst, 1);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_gnt_done", {gnt0, gnt1, done0, done1}, 0);
        chk("rst_result", result, 0);
        chk("rst_modulo", exp_modulo, 0);
        reset = 1'b1;

        // Request before any keys exist must stay pending.
        req1 = 1'b1; mode1 = 1'b1; msg1 = 32'd42;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (gnt0 || gnt1) seen = 1'b1;
        end
        chk("gate_no_gnt", seen, 0);

        p = 32'd61; q = 32'd53; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        chk("keyrst_busy", busy, 1);
        chk("keyrst_inv_rst", inv_rst, 1);
        @(negedge clk);
        chk("keywait_inv_rst", inv_rst, 0);
        wait_high("key_valid_seen", 0, 30);
        chk("key_modulo", exp_modulo, 64'd3233);
        chk("key_busy_low", busy, 0);
        do_job(1, modexp(64'd42, c_e, n_mod), 1'b0, c_e, 64'd42);

        req0 = 1'b1; mode0 = 1'b1; msg0 = 32'd65;
        do_job(0, 64'd2790, 1'b0, c_e, 64'd65);

        req0 = 1'b1; req1 = 1'b1; mode0 = 1'b0; mode1 = 1'b0;
        msg0 = 32'd2790; msg1 = 32'd2790;
        do_job(1, 64'd65, 1'b0, c_d, 64'd2790);
        do_job(0, 64'd65, 1'b0, c_d, 64'd2790);

        // key_load during a job must be dropped.
        req0 = 1'b1; mode0 = 1'b1; msg0 = 32'd100;
        fork
            do_job(0, modexp(64'd100, c_e, n_mod), 1'b0, c_e, 64'd100);
            begin
                repeat (3) @(negedge clk);
                p = 32'd7; q = 32'd11; key_load = 1'b1;
                @(negedge clk);
                key_load = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("busy_load_key_valid", key_valid, 1);
        chk("busy_load_modulo", exp_modulo, 64'd3233);

        pend0 = 1'b0; pend1 = 1'b0; mlast = 0;
        for (int it = 0; it < 12; it++) begin
            if (!pend0 && $urandom_range(1) == 1) begin
                pend0 = 1'b1; req0 = 1'b1; mode0 = 1'($urandom_range(1));
                msg0 = 32'($urandom_range(3232));
            end
            if (!pend1 && ($urandom_range(1) == 1 || !pend0)) begin
                pend1 = 1'b1; req1 = 1'b1; mode1 = 1'($urandom_range(1));
                msg1 = 32'($urandom_range(3232));
            end
            exp_lat = $urandom_range(1, 12);
            win = (pend0 && pend1) ? ((mlast == 1) ? 0 : 1) : (pend1 ? 1 : 0);
            if (win == 1) begin
                ex = mode1 ? c_e : c_d;
                do_job(1, modexp({32'd0, msg1}, ex, n_mod), 1'b0, ex, {32'd0, msg1});
                pend1 = 1'b0;
            end else begin
                ex = mode0 ? c_e : c_d;
                do_job(0, modexp({32'd0, msg0}, ex, n_mod), 1'b0, ex, {32'd0, msg0});
                pend0 = 1'b0;
            end
            mlast = win;
        end
        if (pend0 || pend1) begin
            win = (pend0 && pend1) ? ((mlast == 1) ? 0 : 1) : (pend1 ? 1 : 0);
            ex = (win == 1) ? (mode1 ? c_e : c_d) : (mode0 ? c_e : c_d);
            do_job(win, modexp((win == 1) ? {32'd0, msg1} : {32'd0, msg0}, ex, n_mod), 1'b0, ex,
                   (win == 1) ? {32'd0, msg1} : {32'd0, msg0});
            if (pend0 && pend1) begin
                ex = (win == 1) ? (mode0 ? c_e : c_d) : (mode1 ? c_e : c_d);
                do_job(1 - win, modexp((win == 1) ? {32'd0, msg0} : {32'd0, msg1}, ex, n_mod),
                       1'b0, ex, (win == 1) ? {32'd0, msg0} : {32'd0, msg1});
            end
        end

        // Job timeout: done arrives TIMEOUT+1 cycles into the wait.
        exp_hang = 1'b1;
        req0 = 1'b1; mode0 = 1'b0; msg0 = 32'd5;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (gnt0) seen = 1'b1;
        end
        chk("to_gnt_seen", seen, 1);
        req0 = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (!exp_rst) seen = 1'b1;
        end
        chk("to_wait_entered", seen, 1);
        cnt = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            cnt++;
            if (done0) seen = 1'b1;
        end
        chk("to_latency", cnt, TO + 1);
        chk("to_err", err, 1);
        chk("to_result", result, 0);

        // Asynchronous reset in the middle of a job.
        req1 = 1'b1; mode1 = 1'b1; msg1 = 32'd9;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (gnt1) seen = 1'b1;
        end
        chk("ar_gnt_seen", seen, 1);
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_engine_rst", {inv_rst, exp_rst}, 2'b11);
        chk("ar_key_valid", key_valid, 0);
        chk("ar_result_err", {result, err}, 0);
        chk("ar_exponent", exp_exponent, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done0 || done1) seen = 1'b1;
        end
        chk("ar_no_done", seen, 0);
        exp_hang = 1'b0;

        // Key generation timeout, then recovery.
        inv_hang = 1'b1;
        p = 32'd61; q = 32'd53; key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        wait_high("key_err_seen", 1, 40);
        chk("key_err_valid", key_valid, 0);
        inv_hang = 1'b0;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        chk("key_err_cleared", key_err, 0);
        wait_high("key_valid_again", 0, 30);
        chk("key_modulo_again", exp_modulo, 64'd3233);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
